// File: rtl/alu_pkg.sv
// Purpose : shared ALU op codes and the multiplier state encoding.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Multiplier sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // ALU op codes shared by the cpu, divider and multiplier.
  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;

endpackage

// File: rtl/alu_shared_multiplier_if.sv
// Purpose : start/done execution-unit handshake plus the shared ALU operand/sum path.
// Latency : n/a (wires only).
// Backpressure: none; the requester must not rely on start being seen unless busy is low.
// Signals : start/op_a/op_b (request), alu_req/a_out/b_out/alu_result (shared ALU),
//           busy/done/result (status and product).
interface alu_shared_multiplier_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_req;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // CPU side: issues the request and returns the ALU sum.
  modport master (
    output start, op_a, op_b, alu_result,
    input  alu_req, a_out, b_out, busy, done, result
  );

  // Multiplier side.
  modport slave (
    input  start, op_a, op_b, alu_result,
    output alu_req, a_out, b_out, busy, done, result
  );
endinterface

// File: rtl/alu_shared_multiplier.sv
// Purpose : 16-iteration shift-add unsigned multiplier borrowing the CPU's ALU adder.
// Latency : start edge N -> done in the cycle after edge N+WIDTH (MUL_EARLY_EXIT_EN
//           shortens this to msb-index(op_b)+1 RUN cycles, 0 when op_b is 0).
// Backpressure: none; start is honoured only in IDLE and ignored while busy.
// Ports   : clk, rst_n (async active-low); mul (slave modport): start/op_a/op_b in,
//           alu_req/a_out/b_out out to the ALU mux, alu_result in, busy/done/result out.
// Config  : `define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is 0.
module alu_shared_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_shared_multiplier_if.slave mul
);

  mul_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_iter;

  // The ALU computes acc + mcand; keep it only when the current multiplier bit is set.
  always_comb begin
    acc_next    = mplier[0] ? mul.alu_result : acc;
    mplier_next = mplier >> 1;
`ifdef MUL_EARLY_EXIT_EN
    // No set bits left means every remaining iteration would add nothing.
    last_iter   = (count == CNT_W'(WIDTH - 1)) || (mplier_next == '0);
`else
    last_iter   = (count == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul.start) begin
            acc    <= '0;
            mcand  <= mul.op_a;
            mplier <= mul.op_b;
            count  <= '0;
`ifdef MUL_EARLY_EXIT_EN
            if (mul.op_b == '0) begin
              result_q <= '0;
              state    <= DONE;
            end else begin
              state    <= RUN;
            end
`else
            state  <= RUN;
`endif
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          count  <= count + CNT_W'(1);
          if (last_iter) begin
            result_q <= acc_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are forced to zero outside RUN so the CPU mux sees a quiet bus.
  always_comb begin
    mul.alu_req = (state == RUN);
    mul.a_out   = (state == RUN) ? acc   : '0;
    mul.b_out   = (state == RUN) ? mcand : '0;
    mul.busy    = (state == RUN) || (state == DONE);
    mul.done    = (state == DONE);
    mul.result  = result_q;
  end

endmodule

// File: tb/tb_alu_shared_multiplier.sv
// Purpose : self-checking bench for alu_shared_multiplier (vector table, corner sequences, random).
// Latency : expected start-to-done latency derived from op_b's highest set bit or WIDTH.
// Backpressure: models the CPU adder; returns junk on alu_result whenever alu_req is low.
module tb_alu_shared_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] junk = 16'hDEAD;

  alu_shared_multiplier_if #(.WIDTH(16)) bus ();

  alu_shared_multiplier #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in: real sum while requested, garbage otherwise.
  always @(posedge clk) junk <= 16'($urandom);
  assign bus.alu_result = bus.alu_req ? 16'(bus.a_out + bus.b_out) : junk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = a * b;
    return p[15:0];
  endfunction

  // Number of RUN cycles the reference expects before DONE.
  function automatic int model_lat(input logic [15:0] b);
    int l;
    l = 0;
    for (int i = 0; i < 16; i++) if (b[i]) l = i + 1;
`ifndef MUL_EARLY_EXIT_EN
    l = 16;
`endif
    return l;
  endfunction

  // Pulse start for one cycle; returns at the negedge right after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done (bounded), counting alu_req cycles and any result/busy disturbance.
  task automatic wait_done(input logic [15:0] hold, output logic [15:0] res,
                           output int lat, output int reqs, output int hold_bad);
    lat = 0;
    reqs = 0;
    hold_bad = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.alu_req === 1'b1) reqs++;
      if (bus.result !== hold || bus.busy !== 1'b1) hold_bad++;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    logic [15:0] res;
    logic [15:0] hold;
    int lat, reqs, hb;
    hold = bus.result;
    start_op(a, b);
    wait_done(hold, res, lat, reqs, hb);
    check({name, "_done"}, {31'd0, bus.done}, 32'd1);
    check({name, "_result"}, {16'd0, res}, {16'd0, exp});
    check({name, "_latency"}, lat, model_lat(b));
    check({name, "_alu_req_cycles"}, reqs, model_lat(b));
    check({name, "_hold"}, hb, 0);
    @(negedge clk);
    check({name, "_done_width"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] ra, rb;
    int lat, reqs, hb, dcount;

    vecs[0] = '{16'd3,     16'd5,     16'h000F};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  16'h0001};
    vecs[2] = '{16'h0100,  16'h0100,  16'h0000};
    vecs[3] = '{16'd6,     16'd7,     16'h002A};
    vecs[4] = '{16'h1234,  16'h0011,  16'h3574};
    vecs[5] = '{16'd9,     16'd0,     16'h0000};
    vecs[6] = '{16'h8001,  16'h8000,  16'h8000};

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.done, bus.busy, bus.alu_req, bus.a_out, bus.b_out},
          32'd0);
    check("reset_result", {16'd0, bus.result}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

    // start re-pulsed mid-RUN must not disturb the operation in flight.
    start_op(16'd7, 16'd9);
    bus.start = 1'b1;
    bus.op_a  = 16'd2;
    bus.op_b  = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(16'h8000, res, lat, reqs, hb);
    check("repulse_result", {16'd0, res}, 32'h003F);
    check("repulse_latency", lat + 1, model_lat(16'd9));
    check("repulse_busy_hold", hb, 0);
    dcount = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    check("repulse_single_done", dcount, 0);

    // Asynchronous reset mid-RUN clears everything and produces no done.
    start_op(16'h1234, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {bus.done, bus.busy, bus.alu_req, bus.a_out, bus.b_out},
          32'd0);
    check("midreset_result", {16'd0, bus.result}, 32'd0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
    end
    check("midreset_quiet", dcount, 0);
    rst_n = 1'b1;
    do_op("after_reset", 16'd6, 16'd7, 16'h002A);

    // start during DONE is ignored; start in the following IDLE cycle is accepted.
    start_op(16'd3, 16'd5);
    wait_done(16'h002A, res, lat, reqs, hb);
    check("b2b_first_result", {16'd0, res}, 32'h000F);
    bus.start = 1'b1;
    bus.op_a  = 16'd4;
    bus.op_b  = 16'd4;
    @(negedge clk);
    check("b2b_done_start_ignored", {31'd0, bus.busy}, 32'd0);
    check("b2b_result_holds", {16'd0, bus.result}, 32'h000F);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(16'h000F, res, lat, reqs, hb);
    check("b2b_second_result", {16'd0, res}, 32'h0010);
    check("b2b_second_latency", lat, model_lat(16'd4));
    check("b2b_hold_during_run", hb, 0);
    @(negedge clk);

    // Randomised operands against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      do_op($sformatf("rand%0d", i), ra, rb, model_prod(ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
